// File: rtl/calc_req_sched_if.sv
// Port bundle between the four calc requesters and the request scheduler.
// The scheduler uses the slave view; the requester side uses the master view.
interface calc_req_sched_if;
   logic [15:0] req_cmd_in;
   logic [3:0]  prio_alu1_in_cmd;
   logic [1:0]  prio_alu1_in_req_id;
   logic [3:0]  prio_alu2_in_cmd;
   logic [1:0]  prio_alu2_in_req_id;
   logic        prio_alu1_out_vld;
   logic [1:0]  prio_alu1_out_req_id;
   logic        prio_alu2_out_vld;
   logic [1:0]  prio_alu2_out_req_id;
   logic [7:0]  sched_resp;
   logic [3:0]  port_busy;
   logic        sched_err;

   modport master (
      output req_cmd_in,
      input  prio_alu1_in_cmd, prio_alu1_in_req_id, prio_alu2_in_cmd, prio_alu2_in_req_id,
      input  prio_alu1_out_vld, prio_alu1_out_req_id, prio_alu2_out_vld, prio_alu2_out_req_id,
      input  sched_resp, port_busy, sched_err
   );

   modport slave (
      input  req_cmd_in,
      output prio_alu1_in_cmd, prio_alu1_in_req_id, prio_alu2_in_cmd, prio_alu2_in_req_id,
      output prio_alu1_out_vld, prio_alu1_out_req_id, prio_alu2_out_vld, prio_alu2_out_req_id,
      output sched_resp, port_busy, sched_err
   );
endinterface

// File: rtl/calc_req_sched.sv
// Round-robin scheduler sharing the adder (ALU1) and shifter (ALU2) between 4 request ports.
// Optional protocol checking and sticky sched_err are enabled by defining CALC_SCHED_ERRCHK_EN.
module calc_req_sched #(
   parameter int ALU_LAT = 3
) (
   input logic             c_clk,
   input logic             reset,
   calc_req_sched_if.slave bus
);
   localparam int NP = 4;
   localparam int NU = 2;

   typedef enum logic [1:0] {CLS_NONE, CLS_ALU1, CLS_ALU2, CLS_INV} cls_t;

   function automatic cls_t classify(input logic [3:0] cmd);
      case (cmd)
         4'd0:       classify = CLS_NONE;
         4'd1, 4'd2: classify = CLS_ALU1;
         4'd5, 4'd6: classify = CLS_ALU2;
         default:    classify = CLS_INV;
      endcase
   endfunction

   logic [3:0]    cmd_reg [NP];
   logic [NP-1:0] busy_reg;
   logic [NP-1:0] inv_reg;
   logic [NP-1:0] inv_resp_reg;
   logic [NP-1:0] pend_reg [NU];
   logic [1:0]    ptr_reg [NU];
   logic [3:0]    issue_cmd_reg [NU];
   // Stage 0 is the issue register itself; stage ALU_LAT drives the result valid.
   logic          stage_vld_reg [NU][ALU_LAT+1];
   logic [1:0]    stage_id_reg [NU][ALU_LAT+1];

   logic [3:0]    port_cmd [NP];
   cls_t          port_cls [NP];
   logic [NP-1:0] capture;
   logic [NP-1:0] retire;
   logic [NP-1:0] done_out;
   logic [7:0]    resp;
   logic          gnt [NU];
   logic [1:0]    win [NU];

   genvar gi;
   generate
      for (gi = 0; gi < NP; gi++) begin : g_port
         assign port_cmd[gi] = bus.req_cmd_in[4*gi +: 4];
         assign port_cls[gi] = classify(port_cmd[gi]);
         assign capture[gi]  = !busy_reg[gi] && (port_cmd[gi] != 4'd0);
         // retire fires on the edge that moves the result into the output stage
         assign retire[gi]   = (stage_vld_reg[0][ALU_LAT-1] && (stage_id_reg[0][ALU_LAT-1] == 2'(gi))) ||
                               (stage_vld_reg[1][ALU_LAT-1] && (stage_id_reg[1][ALU_LAT-1] == 2'(gi)));
         assign done_out[gi] = (stage_vld_reg[0][ALU_LAT] && (stage_id_reg[0][ALU_LAT] == 2'(gi))) ||
                               (stage_vld_reg[1][ALU_LAT] && (stage_id_reg[1][ALU_LAT] == 2'(gi)));
         assign resp[2*gi +: 2] = inv_resp_reg[gi] ? 2'b10 : (done_out[gi] ? 2'b01 : 2'b00);
      end
   endgenerate

   always_comb begin
      for (int u = 0; u < NU; u++) begin
         gnt[u] = 1'b0;
         win[u] = 2'd0;
         for (int i = 0; i < NP; i++) begin
            if (!gnt[u] && pend_reg[u][ptr_reg[u] + 2'(i)]) begin
               gnt[u] = 1'b1;
               win[u] = ptr_reg[u] + 2'(i);
            end
         end
      end
   end

   always_ff @(posedge c_clk) begin
      if (reset) begin
         busy_reg     <= '0;
         inv_reg      <= '0;
         inv_resp_reg <= '0;
         for (int n = 0; n < NP; n++) cmd_reg[n] <= 4'd0;
         for (int u = 0; u < NU; u++) begin
            pend_reg[u]      <= '0;
            ptr_reg[u]       <= 2'd0;
            issue_cmd_reg[u] <= 4'd0;
            for (int s = 0; s <= ALU_LAT; s++) begin
               stage_vld_reg[u][s] <= 1'b0;
               stage_id_reg[u][s]  <= 2'd0;
            end
         end
      end else begin
         for (int u = 0; u < NU; u++) begin
            for (int s = ALU_LAT; s > 0; s--) begin
               stage_vld_reg[u][s] <= stage_vld_reg[u][s-1];
               stage_id_reg[u][s]  <= stage_id_reg[u][s-1];
            end
            stage_vld_reg[u][0] <= gnt[u];
            stage_id_reg[u][0]  <= gnt[u] ? win[u] : 2'd0;
            issue_cmd_reg[u]    <= gnt[u] ? cmd_reg[win[u]] : 4'd0;
            if (gnt[u]) begin
               pend_reg[u][win[u]] <= 1'b0;
               ptr_reg[u]          <= win[u] + 2'd1;
            end
         end
         for (int n = 0; n < NP; n++) begin
            inv_resp_reg[n] <= inv_reg[n];
            if (inv_reg[n] || retire[n]) begin
               busy_reg[n] <= 1'b0;
               inv_reg[n]  <= 1'b0;
            end
            // a busy port never captures, so this cannot collide with the clears above
            if (capture[n]) begin
               busy_reg[n] <= 1'b1;
               cmd_reg[n]  <= port_cmd[n];
               case (port_cls[n])
                  CLS_ALU1: pend_reg[0][n] <= 1'b1;
                  CLS_ALU2: pend_reg[1][n] <= 1'b1;
                  CLS_INV:  inv_reg[n]     <= 1'b1;
                  default:  ;
               endcase
            end
         end
      end
   end

   assign bus.prio_alu1_in_cmd     = issue_cmd_reg[0];
   assign bus.prio_alu1_in_req_id  = stage_id_reg[0][0];
   assign bus.prio_alu2_in_cmd     = issue_cmd_reg[1];
   assign bus.prio_alu2_in_req_id  = stage_id_reg[1][0];
   assign bus.prio_alu1_out_vld    = stage_vld_reg[0][ALU_LAT];
   assign bus.prio_alu1_out_req_id = stage_id_reg[0][ALU_LAT];
   assign bus.prio_alu2_out_vld    = stage_vld_reg[1][ALU_LAT];
   assign bus.prio_alu2_out_req_id = stage_id_reg[1][ALU_LAT];
   assign bus.sched_resp           = resp;
   assign bus.port_busy            = busy_reg;

`ifdef CALC_SCHED_ERRCHK_EN
   logic          err_reg;
   logic [NP-1:0] proto_err;

   generate
      for (gi = 0; gi < NP; gi++) begin : g_chk
         assign proto_err[gi] = (busy_reg[gi] && (port_cmd[gi] != 4'd0)) ||
                                (capture[gi] && (port_cls[gi] == CLS_INV));
      end
   endgenerate

   always_ff @(posedge c_clk) begin
      if (reset) begin
         err_reg <= 1'b0;
      end else if (|proto_err) begin
         err_reg <= 1'b1;
      end
   end

`ifndef SYNTHESIS
   always @(posedge c_clk) begin
      for (int n = 0; n < NP; n++) begin
         if (!reset && proto_err[n]) $error("calc_req_sched: protocol error port %0d cmd %0h", n, port_cmd[n]);
      end
   end
`endif

   assign bus.sched_err = err_reg;
`else
   assign bus.sched_err = 1'b0;
`endif
endmodule
